// File: rtl/seg7_capture_if.sv
// Seven-segment bus and decoded-digit bundle shared by seg7_capture and whatever drives or observes it.
// The slave side is the decoder; the master side drives the display pins and reads the digits.
interface seg7_capture_if;
    logic [6:0] seg_in;
    logic [3:0] sel_n;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic [3:0] num4;
    logic [3:0] digit_vld;
    logic       frame_done;
    logic       err;

    modport master (
        output seg_in, sel_n,
        input  num1, num2, num3, num4, digit_vld, frame_done, err
    );

    modport slave (
        input  seg_in, sel_n,
        output num1, num2, num3, num4, digit_vld, frame_done, err
    );
endinterface

// File: rtl/seg7_capture.sv
// Decodes a multiplexed common-anode seven-segment scan bus back into four hex digits,
// filtering scan transitions and ghosting with a synchronizer plus a stability counter.
module seg7_capture #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    seg7_capture_if.slave bus
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(STABLE_CYCLES - 2);

    logic [10:0]      sync_q [SYNC_STAGES];
    logic [10:0]      sync_d [SYNC_STAGES];
    logic [10:0]      prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       num_q [4];
    logic [3:0]       num_d [4];
    logic [3:0]       vld_q, vld_d;
    logic [3:0]       mask_q, mask_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;

    logic [10:0] sample;
    logic [3:0]  smp_sel_n;
    logic [6:0]  smp_seg;
    logic [3:0]  sel_dig;
    logic [3:0]  mask_set;
    logic [4:0]  dec;
    logic        accept;

    // Returns {hit, value}; any code outside the hex font is a miss.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b0000001: decode = {1'b1, 4'h0};
            7'b1001111: decode = {1'b1, 4'h1};
            7'b0010010: decode = {1'b1, 4'h2};
            7'b0000110: decode = {1'b1, 4'h3};
            7'b1001100: decode = {1'b1, 4'h4};
            7'b0100100: decode = {1'b1, 4'h5};
            7'b0100000: decode = {1'b1, 4'h6};
            7'b0001101: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0001100: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b1100000: decode = {1'b1, 4'hB};
            7'b0110001: decode = {1'b1, 4'hC};
            7'b1000010: decode = {1'b1, 4'hD};
            7'b0110000: decode = {1'b1, 4'hE};
            7'b0111000: decode = {1'b1, 4'hF};
            default:    decode = 5'b0;
        endcase
    endfunction

    assign sample    = sync_q[SYNC_STAGES-1];
    assign smp_sel_n = sample[10:7];
    assign smp_seg   = sample[6:0];
    // Bit i of sel_dig is digit D(i+1); sel_n lists D1 in its MSB.
    assign sel_dig   = ~{smp_sel_n[0], smp_sel_n[1], smp_sel_n[2], smp_sel_n[3]};
    assign mask_set  = mask_q | sel_dig;
    assign dec       = decode(smp_seg);
    assign accept    = (sample == prev_q) && (cnt_q == CNT_ACCEPT);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sync_d[0] = {bus.sel_n, bus.seg_in};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        prev_d       = sample;
        cnt_d        = cnt_q;
        vld_d        = vld_q;
        mask_d       = mask_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;
        for (int i = 0; i < 4; i++) num_d[i] = num_q[i];

        if (sample != prev_q)    cnt_d = '0;
        else if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;

        if (accept && (sel_dig != 4'b0000)) begin
            if ($onehot(sel_dig) && dec[4]) begin
                for (int i = 0; i < 4; i++) if (sel_dig[i]) num_d[i] = dec[3:0];
                vld_d = vld_q | sel_dig;
                if (&mask_set) begin
                    frame_done_d = 1'b1;
                    mask_d       = 4'b0000;
                end else begin
                    mask_d = mask_set;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // NOTE: the digit registers are a small array of flops, so they are cleared in reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
            for (int i = 0; i < 4; i++) num_q[i] <= '0;
            prev_q       <= '1;
            cnt_q        <= '0;
            vld_q        <= '0;
            mask_q       <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            for (int i = 0; i < 4; i++) num_q[i] <= num_d[i];
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            vld_q        <= vld_d;
            mask_q       <= mask_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.num1       = num_q[0];
    assign bus.num2       = num_q[1];
    assign bus.num3       = num_q[2];
    assign bus.num4       = num_q[3];
    assign bus.digit_vld  = vld_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: a vector table of dwell patterns with expected digits and
// pulse counts, plus hand sequences for mid-frame reset and an indefinitely held pattern.
module tb_seg7_capture;

    typedef struct {
        logic        do_rst;
        logic        chk;
        logic [3:0]  sel_n;
        logic [6:0]  seg;
        int          cycles;
        logic [15:0] nums;
        logic [3:0]  vld;
        int          errs;
        int          frames;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   err_cnt;
    int   fd_cnt;
    int   both_cnt;

    seg7_capture_if bus ();

    seg7_capture #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.err)        err_cnt++;
            if (bus.frame_done) fd_cnt++;
            if (bus.err && bus.frame_done) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic hold(input logic [3:0] s, input logic [6:0] g, input int n);
        bus.sel_n  = s;
        bus.seg_in = g;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] nums_now();
        return {bus.num1, bus.num2, bus.num3, bus.num4};
    endfunction

    vec_t vecs [15];

    initial begin
        int e0, f0;
        total    = 0;
        passed   = 0;
        err_cnt  = 0;
        fd_cnt   = 0;
        both_cnt = 0;
        rst        = 1'b0;
        bus.sel_n  = 4'b1111;
        bus.seg_in = 7'b1111111;

        //            rst chk sel_n    seg          cyc nums      vld     err frm
        vecs[0]  = '{1'b0, 1'b1, 4'b1110, 7'b0100100, 12, 16'h0005, 4'b1000, 0, 0};
        vecs[1]  = '{1'b1, 1'b1, 4'b0111, 7'b0000110, 10, 16'h3000, 4'b0001, 0, 0};
        vecs[2]  = '{1'b0, 1'b1, 4'b1011, 7'b0001000, 10, 16'h3A00, 4'b0011, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 4'b1101, 7'b0001101, 10, 16'h3A70, 4'b0111, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 4'b1110, 7'b0111000, 10, 16'h3A7F, 4'b1111, 0, 1};
        vecs[5]  = '{1'b0, 1'b1, 4'b0111, 7'b0000001, 10, 16'h0A7F, 4'b1111, 0, 0};
        vecs[6]  = '{1'b0, 1'b1, 4'b1011, 7'b1100000, 10, 16'h0B7F, 4'b1111, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 4'b1101, 7'b0110001, 10, 16'h0BCF, 4'b1111, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 4'b1110, 7'b1000010, 10, 16'h0BCD, 4'b1111, 0, 1};
        // Short glitch of an "8" inside a "3" dwell on D3: only the 3 may land.
        vecs[9]  = '{1'b0, 1'b0, 4'b1101, 7'b0000110,  2, 16'h0000, 4'b0000, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 4'b1101, 7'b0000000,  3, 16'h0000, 4'b0000, 0, 0};
        vecs[11] = '{1'b0, 1'b1, 4'b1101, 7'b0000110, 10, 16'h0B3D, 4'b1111, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 4'b0111, 7'b1111111, 10, 16'h0B3D, 4'b1111, 1, 0};
        vecs[13] = '{1'b0, 1'b1, 4'b0011, 7'b0000001, 10, 16'h0B3D, 4'b1111, 1, 0};
        vecs[14] = '{1'b0, 1'b1, 4'b1111, 7'b1111111, 10, 16'h0B3D, 4'b1111, 0, 0};

        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset nums", 32'(nums_now()), 32'h0);
        check("reset vld", 32'(bus.digit_vld), 32'h0);
        check("reset err", 32'(bus.err), 32'h0);
        check("reset frame_done", 32'(bus.frame_done), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_rst) pulse_rst();
            e0 = err_cnt;
            f0 = fd_cnt;
            hold(vecs[i].sel_n, vecs[i].seg, vecs[i].cycles);
            if (vecs[i].chk) begin
                check($sformatf("v%0d nums", i), 32'(nums_now()), 32'(vecs[i].nums));
                check($sformatf("v%0d vld", i), 32'(bus.digit_vld), 32'(vecs[i].vld));
                check($sformatf("v%0d err pulses", i), 32'(err_cnt - e0), 32'(vecs[i].errs));
                check($sformatf("v%0d frame pulses", i), 32'(fd_cnt - f0), 32'(vecs[i].frames));
            end
        end

        // Mid-frame reset: D1 and D2 captured, then reset, then a full scan starting at D4.
        hold(4'b0111, 7'b0100100, 10);
        hold(4'b1011, 7'b0100000, 10);
        check("pre-rst nums", 32'(nums_now()), 32'h563D);
        bus.sel_n  = 4'b1111;
        bus.seg_in = 7'b1111111;
        rst = 1'b1;
        #1;
        check("in-rst nums", 32'(nums_now()), 32'h0);
        check("in-rst vld", 32'(bus.digit_vld), 32'h0);
        check("in-rst pulses", 32'({bus.err, bus.frame_done}), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        f0 = fd_cnt;
        e0 = err_cnt;
        hold(4'b1110, 7'b1001100, 10);
        check("post-rst D4 nums", 32'(nums_now()), 32'h0004);
        check("post-rst D4 vld", 32'(bus.digit_vld), 32'b1000);
        check("post-rst D4 frame", 32'(fd_cnt - f0), 32'h0);
        hold(4'b0111, 7'b1001111, 10);
        check("post-rst D1 frame", 32'(fd_cnt - f0), 32'h0);
        hold(4'b1011, 7'b0010010, 10);
        check("post-rst D2 frame", 32'(fd_cnt - f0), 32'h0);
        hold(4'b1101, 7'b0000110, 10);
        check("post-rst D3 frame", 32'(fd_cnt - f0), 32'h1);
        check("post-rst nums", 32'(nums_now()), 32'h1234);
        check("post-rst vld", 32'(bus.digit_vld), 32'b1111);
        check("post-rst err", 32'(err_cnt - e0), 32'h0);

        // A pattern held indefinitely is accepted exactly once.
        f0 = fd_cnt;
        e0 = err_cnt;
        hold(4'b1110, 7'b0000001, 100);
        check("long hold nums", 32'(nums_now()), 32'h1230);
        check("long hold err", 32'(err_cnt - e0), 32'h0);
        check("long hold frame", 32'(fd_cnt - f0), 32'h0);
        check("err with frame_done", 32'(both_cnt), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
